// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: register map,
// FSM state encoding and the layout of one replay-table entry.
package pll_reconfig_pkg;

    localparam logic [5:0] REG_MODE   = 6'h00;
    localparam logic [5:0] REG_STATUS = 6'h01;
    localparam logic [5:0] REG_START  = 6'h02;
    localparam logic [5:0] REG_N      = 6'h03;
    localparam logic [5:0] REG_M      = 6'h04;
    localparam logic [5:0] REG_C      = 6'h05;
    localparam logic [5:0] REG_DPS    = 6'h06;
    localparam logic [5:0] REG_KFRAC  = 6'h07;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MODE,
        ST_WR,
        ST_START,
        ST_POLL,
        ST_LOCK,
        ST_DONE,
        ST_FAIL
    } state_t;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } tbl_entry_t;

endpackage

// File: rtl/pll_reconfig_seq_if.sv
// Avalon-MM management port between the sequencer and the pll_reconfig core.
interface pll_reconfig_seq_if;
    logic [5:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/pll_reconfig_seq_avmm_master_if.sv
// Single-outstanding Avalon-MM master: latches a request, holds the strobe
// through waitrequest and returns a one-cycle ack with the read data.
module avmm_master_if
    import pll_reconfig_pkg::*;
(
    input  logic        refclk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic [5:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        ack,
    output logic [31:0] rdata,
    pll_reconfig_seq_if.master bus
);
    logic active;

    // A request is never taken in the cycle a transfer completes, so the
    // FSM can leave req high while it moves to its next state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            active        <= 1'b0;
            bus.read      <= 1'b0;
            bus.write     <= 1'b0;
            bus.address   <= REG_MODE;
            bus.writedata <= '0;
        end else if (active) begin
            if (!bus.waitrequest) begin
                active    <= 1'b0;
                bus.read  <= 1'b0;
                bus.write <= 1'b0;
            end
        end else if (req) begin
            active        <= 1'b1;
            bus.read      <= !req_we;
            bus.write     <= req_we;
            bus.address   <= req_addr;
            bus.writedata <= req_wdata;
        end
    end

    assign ack   = active && !bus.waitrequest;
    assign rdata = bus.readdata;
endmodule

// File: rtl/pll_reconfig_seq.sv
// Replays a host-loaded table of register writes into the PLL reconfig core,
// starts reconfiguration, polls for completion and waits for re-lock.
//   state | meaning
//   IDLE  | waiting for go
//   MODE  | writing polling mode to MODE register
//   WR    | replaying table[idx]
//   START | writing START register
//   POLL  | reading STATUS until bit 0 set
//   LOCK  | waiting for synchronised pll_locked
//   DONE  | one-cycle done pulse
//   FAIL  | poll or lock timeout, error set
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int LOCK_TIMEOUT = 1048576,
    parameter int POLL_LIMIT   = 4096
) (
    input  logic                     refclk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_idx,
    input  logic [5:0]               cfg_addr,
    input  logic [31:0]              cfg_data,
    input  logic [$clog2(DEPTH):0]   cfg_count,
    input  logic                     go,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    pll_reconfig_seq_if.master       mgmt,
    input  logic                     pll_locked
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam int LW = $clog2(LOCK_TIMEOUT + 1);

    state_t          state, state_d;
    tbl_entry_t      tbl [DEPTH];
    tbl_entry_t      cur;
    logic [IW-1:0]   idx, idx_d;
    logic [CW-1:0]   count, count_d, count_sat;
    logic [PW-1:0]   poll_left, poll_left_d;
    logic [LW-1:0]   lock_left, lock_left_d;
    logic            error_d;
    logic [1:0]      lock_sync;
    logic            locked_s;
    logic            req, req_we, ack;
    logic [5:0]      req_addr;
    logic [31:0]     req_wdata, rdata;
    logic            unused_rdata;

    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE);
    assign cur          = tbl[idx];
    assign locked_s     = lock_sync[1];
    assign count_sat    = (cfg_count > CW'(DEPTH)) ? CW'(DEPTH) : cfg_count;
    assign unused_rdata = ^rdata[31:1];

    always_ff @(posedge refclk) begin
        if (cfg_we && !busy) tbl[cfg_idx] <= '{addr: cfg_addr, data: cfg_data};
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) lock_sync <= '0;
        else     lock_sync <= {lock_sync[0], pll_locked};
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            count     <= '0;
            poll_left <= '0;
            lock_left <= '0;
            error     <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            count     <= count_d;
            poll_left <= poll_left_d;
            lock_left <= lock_left_d;
            error     <= error_d;
        end
    end

    always_comb begin
        state_d     = state;
        idx_d       = idx;
        count_d     = count;
        poll_left_d = poll_left;
        lock_left_d = lock_left;
        error_d     = error;
        req         = 1'b0;
        req_we      = 1'b0;
        req_addr    = REG_MODE;
        req_wdata   = '0;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    error_d = 1'b0;
                    if (cfg_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        count_d = count_sat;
                        state_d = ST_MODE;
                    end
                end
            end
            ST_MODE: begin
                req       = 1'b1;
                req_we    = 1'b1;
                req_addr  = REG_MODE;
                req_wdata = 32'h1;
                if (ack) begin
                    idx_d   = '0;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                req       = 1'b1;
                req_we    = 1'b1;
                req_addr  = cur.addr;
                req_wdata = cur.data;
                if (ack) begin
                    if ({1'b0, idx} == count - CW'(1)) state_d = ST_START;
                    else                               idx_d   = idx + IW'(1);
                end
            end
            ST_START: begin
                req       = 1'b1;
                req_we    = 1'b1;
                req_addr  = REG_START;
                if (ack) begin
                    poll_left_d = PW'(POLL_LIMIT - 1);
                    state_d     = ST_POLL;
                end
            end
            ST_POLL: begin
                req      = 1'b1;
                req_addr = REG_STATUS;
                if (ack) begin
                    if (rdata[0]) begin
                        lock_left_d = LW'(LOCK_TIMEOUT - 1);
                        state_d     = ST_LOCK;
                    end else if (poll_left == '0) begin
                        state_d = ST_FAIL;
                    end else begin
                        poll_left_d = poll_left - PW'(1);
                    end
                end
            end
            ST_LOCK: begin
                if (locked_s)               state_d     = ST_DONE;
                else if (lock_left == '0)   state_d     = ST_FAIL;
                else                        lock_left_d = lock_left - LW'(1);
            end
            ST_DONE: state_d = ST_IDLE;
            ST_FAIL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_FAIL) error_d = 1'b1;
    end

    avmm_master_if u_avmm (
        .refclk    (refclk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .rdata     (rdata),
        .bus       (mgmt)
    );
endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Bench for pll_reconfig_seq: scenario table replayed against a bus model,
// plus hand-written sequences for count=0, busy lockout and mid-write reset.
module tb_pll_reconfig_seq;
    import pll_reconfig_pkg::*;

    localparam int DEPTH = 16;
    localparam int LT    = 64;
    localparam int PL    = 8;

    logic        refclk = 1'b0;
    logic        rst, cfg_we, go, busy, done, error, pll_locked;
    logic [3:0]  cfg_idx;
    logic [5:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic [4:0]  cfg_count;

    pll_reconfig_seq_if mgmt();

    pll_reconfig_seq #(.DEPTH(DEPTH), .LOCK_TIMEOUT(LT), .POLL_LIMIT(PL)) dut (
        .refclk(refclk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_count(cfg_count),
        .go(go), .busy(busy), .done(done), .error(error), .mgmt(mgmt),
        .pll_locked(pll_locked)
    );

    always #10 refclk = ~refclk;

    typedef struct packed {
        logic        we;
        logic [5:0]  addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        int wait_n;
        int n_zero;
        int lock_dly;
        bit exp_done;
        bit exp_err;
        int exp_reads;
        bit lock_to;
        bit inject;
    } scen_t;

    xfer_t       xlog[$];
    int          checks = 0, failures = 0;
    int          cyc = 0, hold = 0, rd_cnt = 0, rd_base = 0, ok_cnt = 0, ok_edge = 0;
    int          done_cnt = 0, err_edge = 0, stab_err = 0, wait_n = 0, n_zero = 0;
    logic        prev_err = 1'b0, held_v = 1'b0;
    logic [39:0] held = '0;
    logic [5:0]  sh_addr [3];
    logic [31:0] sh_data [3];
    logic        strobe;
    logic [39:0] bus_now;

    assign strobe           = mgmt.read || mgmt.write;
    assign bus_now          = {mgmt.read, mgmt.write, mgmt.address, mgmt.writedata};
    assign mgmt.waitrequest = strobe && (hold < wait_n);
    assign mgmt.readdata    = ((rd_cnt - rd_base) >= n_zero) ? 32'h1 : 32'h0;

    // Bus slave / monitor: logs completed transfers, checks strobe stability.
    always @(posedge refclk) begin
        cyc <= cyc + 1;
        if (mgmt.read && mgmt.write) stab_err <= stab_err + 1;
        if (rst) begin
            held_v <= 1'b0;
            hold   <= 0;
        end else begin
            if (held_v && bus_now != held) stab_err <= stab_err + 1;
            if (strobe && mgmt.waitrequest) begin
                hold   <= hold + 1;
                held   <= bus_now;
                held_v <= 1'b1;
            end else begin
                hold   <= 0;
                held_v <= 1'b0;
            end
            if (strobe && !mgmt.waitrequest) begin
                xlog.push_back('{mgmt.write, mgmt.address, mgmt.writedata});
                if (mgmt.read) begin
                    rd_cnt <= rd_cnt + 1;
                    if (mgmt.readdata[0]) begin
                        ok_cnt  <= ok_cnt + 1;
                        ok_edge <= cyc;
                    end
                end
            end
        end
        if (done) done_cnt <= done_cnt + 1;
        if (error && !prev_err) err_edge <= cyc;
        prev_err <= error;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_entry(input int i, input logic [5:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_idx = 4'(i); cfg_addr = a; cfg_data = d;
        tick(1);
        cfg_we = 1'b0;
        sh_addr[i] = a; sh_data[i] = d;
    endtask

    task automatic pulse_go(input int cnt);
        cfg_count = 5'(cnt); go = 1'b1;
        tick(1);
        go = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic check_log(input string tag, input int lb, input int reads);
        xfer_t e;
        chk({tag, " log_len"}, 64'(xlog.size()), 64'(lb + 5 + reads));
        for (int k = 0; k < 5 + reads; k++) begin
            if (k == 0)      e = '{1'b1, REG_MODE, 32'h1};
            else if (k <= 3) e = '{1'b1, sh_addr[k-1], sh_data[k-1]};
            else if (k == 4) e = '{1'b1, REG_START, 32'h0};
            else             e = '{1'b0, REG_STATUS, 32'h0};
            if (lb + k < xlog.size()) begin
                if (e.we) chk($sformatf("%s xfer%0d", tag, k), 64'(xlog[lb+k]), 64'(e));
                else      chk($sformatf("%s read%0d", tag, k),
                              64'({xlog[lb+k].we, xlog[lb+k].addr}), 64'({e.we, e.addr}));
            end
        end
    endtask

    task automatic run_scen(input scen_t s, input string tag, input bit coinc);
        int lb, d0, ok0, n;
        wait_n = s.wait_n; n_zero = s.n_zero; rd_base = rd_cnt;
        lb = xlog.size(); d0 = done_cnt; ok0 = ok_cnt;
        pll_locked = 1'b0;
        if (coinc) begin
            cfg_we = 1'b1; cfg_idx = 4'd2; cfg_addr = REG_DPS; cfg_data = 32'h1234_5678;
            sh_addr[2] = REG_DPS; sh_data[2] = 32'h1234_5678;
        end
        pulse_go(3);
        chk({tag, " busy_after_go"}, 64'(busy), 64'(1));
        chk({tag, " err_cleared"}, 64'(error), 64'(0));
        if (s.inject) begin
            cfg_we = 1'b1; cfg_idx = 4'd0; cfg_addr = 6'h3F; cfg_data = 32'hDEAD_BEEF;
            pulse_go(1);
        end
        for (n = 0; n < 2000 && ok_cnt == ok0 && busy; n++) tick(1);
        if (ok_cnt != ok0 && s.lock_dly >= 0) begin
            tick(s.lock_dly);
            pll_locked = 1'b1;
        end
        for (n = 0; n < 2000 && busy; n++) tick(1);
        chk({tag, " finished"}, 64'(busy), 64'(0));
        tick(2);
        chk({tag, " done_pulses"}, 64'(done_cnt - d0), 64'(s.exp_done));
        chk({tag, " error"}, 64'(error), 64'(s.exp_err));
        chk({tag, " stability"}, 64'(stab_err), 64'(0));
        if (s.lock_to) chk({tag, " lock_timeout_edges"}, 64'(err_edge - ok_edge), 64'(LT + 1));
        check_log(tag, lb, s.exp_reads);
    endtask

    scen_t scen [6];

    initial begin
        int lb, d0, n;
        //            wait zero lock done err reads lock_to inject
        scen[0] = '{0,   0,   10,  1,   0,  1,    0,      0};
        scen[1] = '{5,   0,   10,  1,   0,  1,    0,      1};
        scen[2] = '{0,   4,   3,   1,   0,  5,    0,      0};
        scen[3] = '{2,   1,   0,   1,   0,  2,    0,      0};
        scen[4] = '{0,   0,   -1,  0,   1,  1,    1,      0};
        scen[5] = '{1,   100, -1,  0,   1,  PL,   0,      0};

        rst = 1'b1; cfg_we = 1'b0; go = 1'b0; cfg_idx = '0; cfg_addr = '0;
        cfg_data = '0; cfg_count = '0; pll_locked = 1'b1;
        tick(3);
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst error", 64'(error), 64'(0));
        chk("rst strobes", 64'({mgmt.read, mgmt.write}), 64'(0));
        chk("rst addr_data", 64'({mgmt.address, mgmt.writedata}), 64'(0));
        rst = 1'b0;
        tick(1);

        load_entry(0, REG_M, 32'h0000_0808);
        load_entry(1, REG_N, 32'h0001_0000);
        load_entry(2, REG_C, 32'h0002_0404);

        for (int i = 0; i < 6; i++) run_scen(scen[i], $sformatf("scen%0d", i), 1'b0);

        // count=0: done the cycle after go, no bus traffic
        lb = xlog.size(); d0 = done_cnt;
        pulse_go(0);
        chk("cnt0 done", 64'(done), 64'(1));
        tick(4);
        chk("cnt0 no_bus", 64'(xlog.size()), 64'(lb));
        chk("cnt0 done_pulses", 64'(done_cnt - d0), 64'(1));

        // reset during a stalled table write
        wait_n = 100; pll_locked = 1'b0;
        pulse_go(3);
        for (n = 0; n < 200 && !(mgmt.write && mgmt.address == sh_addr[0]); n++) tick(1);
        chk("rst_mid reached_wr", 64'(mgmt.write && mgmt.address == sh_addr[0]), 64'(1));
        rst = 1'b1;
        #1;
        chk("rst_mid write", 64'(mgmt.write), 64'(0));
        chk("rst_mid busy", 64'(busy), 64'(0));
        chk("rst_mid done", 64'(done), 64'(0));
        tick(2);
        rst = 1'b0;
        tick(1);
        run_scen(scen[0], "after_rst", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
Sequences runtime retuning of the system PLL through the Altera PLL reconfiguration core's Avalon-MM management port. Host logic (video-mode switcher) loads a small table of (register address, data) writes, then pulses go. The block sets polling mode, replays the table, issues START, polls for completion and waits for the PLL to re-lock. It reports done or error. It sits between the mode-select logic and the pll_reconfig instance that feeds the pll_0002 reconfig ports.

Parameters:
DEPTH, 16, number of table entries (power of two, 2..64)
LOCK_TIMEOUT, 1048576, refclk cycles allowed for locked to reassert after reconfig completes
POLL_LIMIT, 4096, maximum status reads before declaring error

Ports:
refclk  in  1  management clock, 50 MHz; all logic on rising edge
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  table write strobe, ignored while busy=1
cfg_idx  in  log2(DEPTH)  table entry index
cfg_addr  in  6  reconfig register address for the entry
cfg_data  in  32  reconfig register data for the entry
cfg_count  in  log2(DEPTH)+1  number of entries to replay, sampled on go
go  in  1  start pulse, ignored while busy=1
busy  out  1  sequence in progress
done  out  1  one-cycle pulse on successful completion
error  out  1  sticky; set on timeout; cleared on next accepted go
mgmt_address  out  6  Avalon-MM address
mgmt_read  out  1  Avalon-MM read
mgmt_write  out  1  Avalon-MM write
mgmt_writedata  out  32  Avalon-MM write data
mgmt_readdata  in  32  Avalon-MM read data
mgmt_waitrequest  in  1  Avalon-MM stall
pll_locked  in  1  PLL locked, asynchronous to refclk

Behaviour:
- Reset (async, immediate): busy=0, done=0, error=0, mgmt_read=0, mgmt_write=0, mgmt_address=0, mgmt_writedata=0, state IDLE. Table contents are not reset. Reset mid-sequence drops bus strobes immediately. The mgmt side is reset together with this block.
- pll_locked passes through a 2-FF synchroniser before use; the added latency is 2 cycles.
- Avalon rules: address, data and strobe stay stable until the cycle where strobe=1 and waitrequest=0; that cycle completes the transfer. Read data is sampled in the completing cycle. read and write are never asserted together.
- Table: a single-port register array, DEPTH x 38 bits, written on cfg_we when not busy.
- States:
  IDLE: on go with cfg_count=0, pulse done the next cycle with no bus activity. On go with cfg_count>0, latch the count, clear error, set busy, go to MODE.
  MODE: write addr 0x00 data 0x1 (polling mode), then go to WR with index 0.
  WR: write table[idx]. On completion, idx++. When idx=count-1 completes, go to START.
  START: write addr 0x02 data 0x0. On completion, go to POLL.
  POLL: read addr 0x01. If readdata[0]=1, go to LOCK. Otherwise re-issue the read the next cycle. After POLL_LIMIT reads, go to FAIL.
  LOCK: count cycles while synced locked=0. On synced locked=1, go to DONE. If the counter reaches LOCK_TIMEOUT, go to FAIL.
  DONE: done=1 for 1 cycle, busy=0, return to IDLE.
  FAIL: error=1, busy=0, no done pulse, return to IDLE.
- busy is 1 from the cycle after go through DONE/FAIL inclusive, and drops the cycle after.
- A go pulse coinciding with cfg_we: the write is accepted (not busy) and go samples the new table.
- cfg_count > DEPTH saturates to DEPTH.
- Counters saturate and never wrap.

Decomposition:
- Package pll_reconfig_pkg holds:
  - register address constants: MODE=0x00, STATUS=0x01, START=0x02, N=0x03, M=0x04, C=0x05, DPS=0x06, KFRAC=0x07
  - the state enum
  - the table entry typedef (addr 6 + data 32)
- One sub-module, avmm_master_if: a single-transaction Avalon-MM master handling strobe hold and waitrequest, with req/ack handshake to the FSM.

Test Plan:
- Load 3 entries (0x04/0x00000808, 0x03/0x00010000, 0x05/0x00020404), count=3, go; waitrequest low, status returns 1 on the first read, locked drops then rises after 10 cycles -> bus shows writes 0x00=1, the three entries in order, 0x02=0, one read of 0x01, then a done pulse; busy high throughout; error=0.
- Same sequence with waitrequest held high for 5 cycles on every transfer -> address, data and strobes stay stable for those cycles; each transfer completes exactly once; same final result.
- Status returns 0 four times then 1 -> exactly 5 reads issued; done asserts.
- LOCK_TIMEOUT=64 with locked held low -> error=1 after 64 cycles in LOCK; no done; busy=0. The next go clears error.
- cfg_count=0 go -> done the cycle after go; no mgmt strobes. Go and cfg_we while busy -> ignored, with the table unchanged (verified by a replay).
- Assert rst during the WR state while waitrequest=1 -> mgmt_write, busy and done are 0 in the same cycle; the next go runs the full sequence from MODE.
